// File: rtl/boot_loader.sv
// boot_loader: streams a length-prefixed little-endian program image into memory while holding the CPU halted.
// Optional feature macro BOOT_LOADER_CHECKSUM_EN appends a 32-bit additive checksum after the payload.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        mem_rw,
  output logic [31:0] mem_aout,
  output logic [31:0] mem_dout,
  output logic        halt,
  output logic        done,
  output logic        error
);
`ifdef BOOT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR} state_t;
  localparam state_t S_FIN = S_CSUM;
  logic [31:0] sum_q;
`else
  typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_DONE, S_ERROR} state_t;
  localparam state_t S_FIN = S_DONE;
`endif
  state_t      st_q, st_d;
  logic [1:0]  cnt_q;
  logic [23:0] sh_q;
  logic [31:0] rem_q, nxt_q, aout_q, dout_q, word_d;
  logic        rdy_q, rw_q, halt_q, done_q, err_q, acc_d, last_d, rdy_d;
  assign rx_ready = rdy_q;
  assign mem_rw   = rw_q;
  assign mem_aout = aout_q;
  assign mem_dout = dout_q;
  assign halt     = halt_q;
  assign done     = done_q;
  assign error    = err_q;
  // Next state from the byte being accepted this cycle (assembled little-endian)
  always_comb begin
    word_d = {rx_data, sh_q};
    acc_d  = rx_valid && rdy_q;
    last_d = acc_d && cnt_q == 2'd3;
    st_d   = st_q;
    case (st_q)
      S_LEN:   if (last_d) st_d = word_d == 32'd0 ? S_FIN : word_d > MAX_WORDS ? S_ERROR : S_DATA;
      S_DATA:  if (last_d) st_d = S_WRITE;
      S_WRITE: st_d = rem_q == 32'd1 ? S_FIN : S_DATA;
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_CSUM:  if (last_d) st_d = word_d == sum_q ? S_DONE : S_ERROR;
`endif
      default: st_d = st_q;
    endcase
`ifdef BOOT_LOADER_CHECKSUM_EN
    rdy_d = st_d == S_LEN || st_d == S_DATA || st_d == S_CSUM;
`else
    rdy_d = st_d == S_LEN || st_d == S_DATA;
`endif
  end
  // State, datapath and registered outputs; all outputs follow the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q   <= S_LEN;
      cnt_q  <= 2'd0;
      sh_q   <= 24'd0;
      rem_q  <= 32'd0;
      nxt_q  <= BASE_ADDR;
      aout_q <= BASE_ADDR;
      dout_q <= 32'd0;
      rdy_q  <= 1'b0;
      rw_q   <= 1'b0;
      halt_q <= 1'b1;
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q  <= 32'd0;
`endif
    end else begin
      st_q  <= st_d;
      cnt_q <= st_d != st_q ? 2'd0 : acc_d ? cnt_q + 2'd1 : cnt_q;
      if (acc_d) sh_q <= word_d[31:8];
      if (st_q == S_LEN && last_d) rem_q <= word_d;
      if (st_q == S_DATA && last_d) begin
        dout_q <= word_d;
        aout_q <= nxt_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum_q  <= sum_q + word_d;
`endif
      end
      if (st_q == S_WRITE) begin
        rem_q <= rem_q - 32'd1;
        nxt_q <= nxt_q + 32'd4;
      end
      rdy_q  <= rdy_d;
      rw_q   <= st_d == S_WRITE;
      halt_q <= st_d != S_DONE;
      done_q <= st_d == S_DONE;
      err_q  <= st_d == S_ERROR;
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized stream loads checked against an image-level reference model.
module tb_boot_loader;
  localparam logic [31:0] BASE = 32'h100;
  localparam int MAXW = 8;
  logic        clock = 0, reset = 0, rx_valid = 0;
  logic [7:0]  rx_data = 0;
  logic        rx_ready, mem_rw, halt, done, error;
  logic [31:0] mem_aout, mem_dout;
  int          n_vec = 0, n_bad = 0, cyc = 0, last_wr = -1, done_cyc = -1, clash = 0;
  logic [31:0] obs_a[$], obs_d[$], exp_a[$], exp_d[$], ref_a[$], ref_d[$];
  bit          exp_done, exp_err;

  boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .mem_rw(mem_rw), .mem_aout(mem_aout), .mem_dout(mem_dout), .halt(halt), .done(done), .error(error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      obs_a.delete(); obs_d.delete(); last_wr = -1; done_cyc = -1; clash = 0;
    end else begin
      if (mem_rw) begin obs_a.push_back(mem_aout); obs_d.push_back(mem_dout); last_wr = cyc; end
      if (mem_rw && rx_ready) clash++;
      if (done && done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, 32'(rx_ready), 0);
    chk({tag, "_rw"}, 32'(mem_rw), 0);
    chk({tag, "_aout"}, mem_aout, BASE);
    chk({tag, "_dout"}, mem_dout, 0);
    chk({tag, "_halt"}, 32'(halt), 1);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(error), 0);
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset = 0; rx_valid = 0;
    #1 chk_reset_vals("rst");
    repeat (2) @(negedge clock);
    reset = 1;
    @(negedge clock);
    chk("rdy_after_rst", 32'(rx_ready), 1);
  endtask

  task automatic send(input logic [7:0] b, input int gap, output bit ok);
    repeat (gap) @(negedge clock);
    rx_valid = 1; rx_data = b; ok = 0;
    for (int t = 0; t < 32 && !ok; t++) begin
      ok = rx_ready;
      @(negedge clock);
    end
    rx_valid = 0; rx_data = 8'($urandom);
  endtask

  task automatic stream(input logic [7:0] q[$], input int maxgap);
    bit ok;
    foreach (q[i]) begin
      send(q[i], $urandom_range(maxgap, 0), ok);
      chk("accept", 32'(ok), 1);
      if (!ok) break;
    end
  endtask

  function automatic void push_word(ref logic [7:0] q[$], input logic [31:0] w);
    for (int k = 0; k < 4; k++) q.push_back(8'(w >> (8 * k)));
  endfunction

  function automatic void build(input logic [31:0] w[$], input logic [31:0] adj, output logic [7:0] q[$]);
    logic [31:0] s = adj;
    q = {};
    push_word(q, 32'(w.size()));
    foreach (w[i]) begin push_word(q, w[i]); s += w[i]; end
`ifdef BOOT_LOADER_CHECKSUM_EN
    push_word(q, s);
`endif
  endfunction

  function automatic void model(input logic [7:0] q[$]);
    logic [31:0] len, w, s = 0;
    exp_a.delete(); exp_d.delete(); exp_done = 0; exp_err = 0;
    if (q.size() < 4) return;
    len = {q[3], q[2], q[1], q[0]};
    if (len > MAXW) begin exp_err = 1; return; end
    for (int i = 0; i < int'(len); i++) begin
      if (q.size() < 8 + 4 * i) return;
      w = {q[7 + 4 * i], q[6 + 4 * i], q[5 + 4 * i], q[4 + 4 * i]};
      exp_a.push_back(BASE + 32'(4 * i));
      exp_d.push_back(w);
      s += w;
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    if (q.size() < 8 + 4 * int'(len)) return;
    w = {q[7 + 4 * len], q[6 + 4 * len], q[5 + 4 * len], q[4 + 4 * len]};
    exp_done = w == s;
    exp_err = w != s;
`else
    exp_done = 1;
`endif
  endfunction

  task automatic verify(input string tag);
    repeat (3) @(negedge clock);
    chk({tag, "_nwr"}, obs_a.size(), exp_a.size());
    foreach (exp_a[i]) if (i < obs_a.size()) begin
      chk({tag, "_addr"}, obs_a[i], exp_a[i]);
      chk({tag, "_data"}, obs_d[i], exp_d[i]);
    end
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_err"}, 32'(error), 32'(exp_err));
    chk({tag, "_halt"}, 32'(halt), 32'(!exp_done));
    chk({tag, "_clash"}, clash, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  q[$];
    logic [31:0] w[$];
    bit ok;
    do_reset;
    build('{32'h13, 32'h6F}, 0, q);
    model(q);
    stream(q, 0);
    verify("two");
`ifndef BOOT_LOADER_CHECKSUM_EN
    chk("two_done_lat", done_cyc - last_wr, 1);
`endif

    do_reset;
    build('{}, 0, q);
    model(q);
    stream(q, 0);
    chk("len0_done_now", 32'(done), 1);
    chk("len0_halt_now", 32'(halt), 0);
    verify("len0");

    do_reset;
    q = '{8'(MAXW + 1), 8'h00, 8'h00, 8'h00};
    model(q);
    stream(q, 0);
    chk("big_err_now", 32'(error), 1);
    chk("big_rdy_now", 32'(rx_ready), 0);
    send(8'hAA, 0, ok);
    chk("big_ignored", 32'(ok), 0);
    verify("big");

    w = '{$urandom, $urandom, $urandom};
    build(w, 0, q);
    model(q);
    do_reset;
    stream(q, 0);
    verify("nogap");
    ref_a = obs_a; ref_d = obs_d;
    do_reset;
    stream(q, 7);
    verify("gap");
    chk("gap_vs_ref_n", obs_a.size(), ref_a.size());
    foreach (ref_a[i]) if (i < obs_a.size()) begin
      chk("gap_vs_ref_a", obs_a[i], ref_a[i]);
      chk("gap_vs_ref_d", obs_d[i], ref_d[i]);
    end

    for (int r = 0; r < 6; r++) begin
      w = {};
      repeat ($urandom_range(MAXW, 1)) w.push_back($urandom);
      build(w, 0, q);
      model(q);
      do_reset;
      stream(q, 3);
      verify("rand");
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    do_reset;
    build('{32'h13}, 0, q);
    model(q);
    stream(q, 0);
    verify("csum_ok");
    do_reset;
    build('{32'h13}, 1, q);
    model(q);
    stream(q, 0);
    verify("csum_bad");
`endif

    do_reset;
    build('{32'hDEADBEEF, 32'h6F}, 0, q);
    for (int i = 0; i < 10; i++) begin
      send(q[i], 0, ok);
      chk("mid_accept", 32'(ok), 1);
    end
    #2 reset = 0;
    #1 chk_reset_vals("mid");
    do_reset;
    build('{32'h13, 32'h6F}, 0, q);
    model(q);
    stream(q, 1);
    verify("after_mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
